// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between NREQ requesters.
// Only one operation is in flight at a time. The ALU clock enable is held
// for the operation's latency, and the result is returned tagged with the
// index of the requester that issued it.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner
// ISSUE | first ALU cycle; loads the latency counter
// WAIT  | ALU computing; captures the result when cnt reaches 0
// RESP  | response presented until the consumer takes it
module alu_req_arbiter #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int NREQ    = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [NREQ*CW-1:0]   req_cmd,
    input  logic [NREQ*2-1:0]    req_inp_valid,
    input  logic [NREQ*DW-1:0]   req_opa,
    input  logic [NREQ*DW-1:0]   req_opb,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 alu_ce,
    output logic                 alu_mode,
    output logic                 alu_cin,
    output logic [CW-1:0]        alu_cmd,
    output logic [1:0]           alu_inp_valid,
    output logic [DW-1:0]        alu_opa,
    output logic [DW-1:0]        alu_opb,
    input  logic [DW:0]          alu_res,
    input  logic                 alu_err,
    input  logic                 alu_oflow,
    input  logic                 alu_cout,
    input  logic                 alu_g,
    input  logic                 alu_l,
    input  logic                 alu_e,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [DW:0]          rsp_res,
    output logic [5:0]           rsp_flags,
    output logic                 busy
);

    localparam int MAXL = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int CNTW = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [CNTW-1:0] cnt;
    logic [1:0]      op_inp_valid;
    logic [IW-1:0]   win_id;
    logic            win_found;
    logic [IW-1:0]   idx;
    logic [1:0]      win_inp_valid;
    logic [IW-1:0]   ptr_inc;
    logic            is_mul;

    // Winner search: first set req_valid bit starting at ptr, wrapping at NREQ.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign win_inp_valid = req_inp_valid[win_id*2 +: 2];
    assign ptr_inc       = (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
    // Multiply/divide-class commands only take the long latency in mode 1.
    assign is_mul        = alu_mode && (alu_cmd == CW'(9) || alu_cmd == CW'(10));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and handshake/ALU-control outputs.
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        alu_ce        = 1'b0;
        alu_inp_valid = 2'b00;
        rsp_valid     = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    state_nxt = (win_inp_valid == 2'b00) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                alu_ce        = 1'b1;
                alu_inp_valid = op_inp_valid;
                state_nxt     = WAIT;
            end
            WAIT: begin
                alu_ce        = 1'b1;
                alu_inp_valid = op_inp_valid;
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, latency counter and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            cnt          <= '0;
            op_inp_valid <= 2'b00;
            alu_mode     <= 1'b0;
            alu_cin      <= 1'b0;
            alu_cmd      <= '0;
            alu_opa      <= '0;
            alu_opb      <= '0;
            rsp_id       <= '0;
            rsp_res      <= '0;
            rsp_flags    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        ptr    <= ptr_inc;
                        rsp_id <= win_id;
                        if (win_inp_valid == 2'b00) begin
                            // No operands: answer with an error and leave the ALU untouched.
                            rsp_res   <= '0;
                            rsp_flags <= 6'b100000;
                        end else begin
                            op_inp_valid <= win_inp_valid;
                            alu_mode     <= req_mode[win_id];
                            alu_cin      <= req_cin[win_id];
                            alu_cmd      <= req_cmd[win_id*CW +: CW];
                            alu_opa      <= req_opa[win_id*DW +: DW];
                            alu_opb      <= req_opb[win_id*DW +: DW];
                        end
                    end
                end
                ISSUE: cnt <= is_mul ? CNTW'(MUL_LAT - 1) : CNTW'(LAT - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_res   <= alu_res;
                        rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one ALU instance between NREQ independent requesters. It accepts operation requests under a valid/ready handshake and grants them round-robin. Each granted operation is issued to the ALU with clock enable held for the operation's latency, and the ALU result and flags are returned to the winning requester, tagged with its index. The block sits between the requester-side logic and the ALU's input/output ports. It owns alu_ce and all ALU operand and command inputs.

## Interface
- DW, 8, operand width; the ALU result is DW+1 bits.
- CW, 4, command width.
- NREQ, 4, number of requesters (2..8); IW = $clog2(NREQ).
- LAT, 1, ALU latency in cycles for ordinary commands (≥1).
- MUL_LAT, 2, ALU latency in cycles when mode=1 and cmd is 9 or 10 (≥1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  one bit per requester.
- req_ready  out  NREQ  one-hot grant; asserted in the accept cycle.
- req_mode  in  NREQ  per-requester mode.
- req_cmd  in  NREQ*CW  per-requester command.
- req_inp_valid  in  NREQ*2  per-requester operand-valid field.
- req_opa, req_opb  in  NREQ*DW  per-requester operands.
- req_cin  in  NREQ  per-requester carry-in.
- alu_ce, alu_mode, alu_cin  out  1  ALU controls.
- alu_cmd  out  CW  ALU command.
- alu_inp_valid  out  2  ALU operand-valid field.
- alu_opa, alu_opb  out  DW  ALU operands.
- alu_res  in  DW+1  ALU result.
- alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IW  index of the requester the response belongs to.
- rsp_res  out  DW+1  captured result.
- rsp_flags  out  6  {err, oflow, cout, g, l, e}.
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- **IDLE**
  - If any req_valid bit is high, the winner is the first set bit searched from ptr upward, modulo NREQ.
  - req_ready[winner]=1 combinationally in this cycle; every other ready bit is 0.
  - The winner's fields and index are captured. ptr becomes winner+1 (mod NREQ).
  - If the captured inp_valid==2'b00, the request short-circuits: go to RESP with rsp_res=0 and rsp_flags=6'b100000 (err only). The ALU is never driven for this request.
  - Otherwise go to ISSUE.
- **ISSUE**
  - alu_* outputs carry the captured op and alu_ce=1.
  - cnt is loaded with L-1, where L = MUL_LAT if (mode && (cmd==9 || cmd==10)), else L = LAT. Go to WAIT.
- **WAIT**
  - alu_* outputs are held unchanged and alu_ce=1.
  - If cnt==0: capture alu_res and the six flags into the rsp registers and go to RESP. Otherwise decrement cnt.
- **RESP**
  - rsp_valid=1. rsp_id, rsp_res and rsp_flags are stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- Outside ISSUE/WAIT: alu_ce=0 and alu_inp_valid=0. alu_opa, alu_opb, alu_cmd, alu_mode and alu_cin hold their last values.
- Requester obligations: the request fields must be stable while req_valid is high. req_valid may drop before a grant; no request is retained on the arbiter side.
- Only one operation is in flight at a time; there is no queuing.

## Timing
- **Reset values:** state=IDLE, ptr=0, cnt=0, req_ready=0, alu_ce=0, alu_inp_valid=0, alu_mode=0, alu_cmd=0, alu_opa=0, alu_opb=0, alu_cin=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0, busy=0.
- **Normal latency:** with the accept in cycle T, ISSUE is T+1, WAIT spans T+2..T+1+L, and rsp_valid rises at T+2+L.
- **Short-circuit latency:** rsp_valid rises at T+1.
- **Back-to-back accepts:** after a response handshake in cycle R, the earliest next accept is R+1. Minimum spacing between accepts is L+3 cycles.
- **Simultaneous requests:** the grant rotates, so every continuously requesting port is served within NREQ accepts.
- **Reset mid-operation:** asserting rst in any state returns all registers to their reset values immediately. The in-flight operation is dropped and no response is produced.
- **Held response:** rsp_ready low holds RESP indefinitely. New requests are not granted while in RESP.

## Test plan
- **Single op:** after reset, req_valid[2]=1, mode=1, cmd=0 (ADD), opa=8'h0F, opb=8'h01, inp_valid=2'b11, LAT=1. Required: req_ready=4'b0100 in T; alu_ce=1 in T+1..T+2; rsp_valid in T+3 with rsp_id=2 and rsp_res=9'h010.
- **Round-robin:** hold req_valid=4'b1111 continuously with rsp_ready=1. Required: grant order 0,1,2,3,0, with each accept L+3 cycles apart.
- **Multiply latency:** mode=1, cmd=9, MUL_LAT=2. Required: alu_ce high for 3 cycles; rsp_valid at T+4.
- **Invalid operands:** inp_valid=2'b00. Required: alu_ce never asserted; rsp_valid at T+1 with rsp_flags=6'b100000 and rsp_res=0.
- **Backpressure:** rsp_ready=0 for 5 cycles while req_valid[1]=1. Required: rsp_* held stable, req_ready stays 0, and the accept follows the cycle after rsp_ready=1.
- **Reset in WAIT:** rst=0 during WAIT. Required: alu_ce=0, rsp_valid=0, busy=0 and ptr=0 in the same cycle, and no response after release.
